// File: rtl/byte_stream_packer_if.sv
// Byte stream packer bus bundle.
//   Input side : in_valid/in_ready handshake carrying a right-justified chunk
//                (in_data, in_bytes), packet framing (in_first, in_last) and
//                the destination byte offset of the packet's first byte.
//   Output side: out_valid/out_ready handshake carrying an aligned word
//                (out_data) with per-byte enables (out_strb) and out_last.
// slave  : the packer's view (consumes chunks, produces words).
// master : the environment's view (produces chunks, consumes words).
interface byte_stream_packer_if #(
  parameter int NB = 16
);
  localparam int LW = $clog2(NB);

  logic            in_valid;
  logic            in_ready;
  logic [NB*8-1:0] in_data;
  logic [LW:0]     in_bytes;
  logic            in_first;
  logic [LW-1:0]   in_offset;
  logic            in_last;

  logic            out_valid;
  logic            out_ready;
  logic [NB*8-1:0] out_data;
  logic [NB-1:0]   out_strb;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, in_bytes, in_first, in_offset, in_last,
    output in_ready,
    output out_valid, out_data, out_strb, out_last,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_bytes, in_first, in_offset, in_last,
    input  in_ready,
    input  out_valid, out_data, out_strb, out_last,
    output out_ready
  );
endinterface

// File: rtl/byte_stream_packer.sv
// byte_stream_packer
//   Packs variable-length, right-justified byte chunks into contiguous
//   NB-byte aligned words with per-byte strobes. The first word of a packet
//   may start mid-line at in_offset (leading bytes carry strobe 0).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : byte_stream_packer_if.slave (input chunk stream, output words)
module byte_stream_packer #(
  parameter int NB = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  byte_stream_packer_if.slave  bus
);
  localparam int LW = $clog2(NB);
  localparam int DW = NB * 8;

  typedef enum logic {ACCUM, FLUSH} state_t;

  // Byte counts above NB are saturated to a full beat.
  function automatic logic [LW:0] clamp_bytes(input logic [LW:0] b);
    return (b > (LW+1)'(NB)) ? (LW+1)'(NB) : b;
  endfunction

  // One bit set for every byte position below k.
  function automatic logic [NB-1:0] byte_mask(input logic [LW:0] k);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = ((LW+1)'(i) < k);
    return m;
  endfunction

  function automatic logic [DW-1:0] expand_strb(input logic [NB-1:0] m);
    logic [DW-1:0] e;
    for (int i = 0; i < NB; i++) e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [NB-1:0]   res_strb_q, res_strb_d;

  logic            vld_p0, vld_p1;
  logic [DW-1:0]   data_p0, data_p1;
  logic [NB-1:0]   strb_p0, strb_p1;
  logic            last_p0, last_p1;

  logic            out_free;
  logic            in_ready;
  logic            accept;
  logic [LW:0]     n;
  logic [LW-1:0]   base_cnt;
  logic [DW-1:0]   base_data;
  logic [NB-1:0]   base_strb;
  logic [2*DW-1:0] win_data;
  logic [2*NB-1:0] win_strb;
  logic [LW+1:0]   s;

  assign out_free = !vld_p1 || bus.out_ready;
  assign in_ready = rst_n && (state_q == ACCUM) && out_free;
  assign accept   = bus.in_valid && in_ready;

  // Stage 0: merge the residual with the incoming chunk in a 2*NB window
  always_comb begin
    n         = clamp_bytes(bus.in_bytes);
    // in_first restarts the buffer with a hole of in_offset unstrobed bytes;
    // any leftover residual is dropped.
    base_cnt  = bus.in_first ? bus.in_offset : cnt_q;
    base_strb = bus.in_first ? '0 : res_strb_q;
    // Residual data is not reset, so it is qualified by its strobes here.
    base_data = bus.in_first ? '0 : (res_data_q & expand_strb(res_strb_q));
    win_data  = {{DW{1'b0}}, base_data}
              | ({{DW{1'b0}}, bus.in_data & expand_strb(byte_mask(n))} << {base_cnt, 3'b000});
    win_strb  = {{NB{1'b0}}, base_strb} | ({{NB{1'b0}}, byte_mask(n)} << base_cnt);
    s         = (LW+2)'(base_cnt) + (LW+2)'(n);

    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_strb_d = res_strb_q;
    vld_p0     = vld_p1 && !bus.out_ready;
    data_p0    = data_p1;
    strb_p0    = strb_p1;
    last_p0    = last_p1;

    if (state_q == FLUSH) begin
      if (out_free) begin
        vld_p0     = 1'b1;
        data_p0    = res_data_q & expand_strb(res_strb_q);
        strb_p0    = res_strb_q;
        last_p0    = 1'b1;
        cnt_d      = '0;
        res_strb_d = '0;
        state_d    = ACCUM;
      end
    end else if (accept) begin
      if (s >= (LW+2)'(NB)) begin
        vld_p0     = 1'b1;
        data_p0    = win_data[DW-1:0];
        strb_p0    = win_strb[NB-1:0];
        last_p0    = bus.in_last && (s == (LW+2)'(NB));
        res_data_d = win_data[2*DW-1:DW];
        res_strb_d = win_strb[2*NB-1:NB];
        cnt_d      = LW'(s - (LW+2)'(NB));
        // Overflow bytes of a final beat need a second word.
        if (bus.in_last && (s != (LW+2)'(NB))) state_d = FLUSH;
      end else if (bus.in_last) begin
        // Short final word, also covers a zero-length packet end.
        vld_p0     = 1'b1;
        data_p0    = win_data[DW-1:0];
        strb_p0    = win_strb[NB-1:0];
        last_p0    = 1'b1;
        cnt_d      = '0;
        res_strb_d = '0;
      end else begin
        res_data_d = win_data[DW-1:0];
        res_strb_d = win_strb[NB-1:0];
        cnt_d      = LW'(s);
      end
    end
  end

  // Stage 1: output word register and residual/FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      res_strb_q <= '0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      strb_p1    <= '0;
      last_p1    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_strb_q <= res_strb_d;
      vld_p1     <= vld_p0;
      data_p1    <= data_p0;
      strb_p1    <= strb_p0;
      last_p1    <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    res_data_q <= res_data_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_strb  = strb_p1;
  assign bus.out_last  = last_p1;
endmodule

// File: doc/byte_stream_packer.md
Name: byte_stream_packer

Overview:
- Write-side counterpart of the 128-bit byte rotator on the read path.
- Accepts a stream of variable-length byte chunks, each right-justified in a 128-bit beat.
- Packs the chunks into contiguous, 16-byte-aligned output words with per-byte strobes.
- Sits between the unaligned producer and the aligned memory write port. The optional starting destination offset lets the first word begin mid-line.

Parameters:
- NB, 16, bytes per word. Must be a power of two. The data width is NB*8.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  NB*8  chunk bytes; byte k is in_data[8k+7:8k]; valid bytes occupy k = 0..in_bytes-1.
- in_bytes  input  log2(NB)+1  number of valid bytes, 0..NB.
- in_first  input  1  first beat of a packet; in_offset applies.
- in_offset  input  log2(NB)  destination byte offset of the packet's first byte in its first output word.
- in_last  input  1  last beat of the packet.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  NB*8  aligned word.
- out_strb  output  NB  byte enables; bit k qualifies byte k.
- out_last  output  1  final word of the packet.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_last=0, out_strb=0, out_data=0, in_ready=0 during reset.
  - Internal residual count cnt=0, residual strobes=0, state=ACCUM.
  - Reset mid-packet discards all buffered bytes. No output follows until new input arrives.
- Handshakes:
  - An input beat transfers on the edge where in_valid&&in_ready.
  - An output word transfers on the edge where out_valid&&out_ready.
  - Once asserted, out_valid, out_data, out_strb and out_last hold until transfer.
- in_ready = (state==ACCUM) && (!out_valid || out_ready). A single output register absorbs the stall.
- Residual buffer:
  - Holds cnt bytes (0..NB-1) at byte positions 0..cnt-1, plus a strobe per position.
  - On in_first, the buffer is first set to cnt=in_offset with strobes 0 on positions 0..in_offset-1 (leading hole).
  - A non-empty residual at in_first is an illegal stimulus; the residual is discarded.
- Accept of a beat with n=min(in_bytes,NB) bytes:
  - The new bytes are placed at positions cnt..cnt+n-1 of a 2*NB-byte merge window, with strobes 1.
  - Let s=cnt+n.
  - If s>=NB: the low NB bytes of the window go to the output register on the next edge, with out_last = in_last && s==NB. The high s-NB bytes become the new residual at positions 0..s-NB-1.
  - If s<NB and !in_last: no output; cnt=s.
  - If s<NB and in_last: emit the window's low NB bytes with strobes set on filled positions only, out_last=1, cnt=0.
  - If in_last and s>NB: emit the full word (out_last=0) and enter state FLUSH.
  - in_bytes=0 without in_last: the beat is consumed with no effect on cnt.
  - in_bytes=0 with in_last and cnt==0: emit one word with out_strb=0 and out_last=1. Packet end is never lost.
- FLUSH:
  - in_ready=0.
  - When the output register is free (or transfers this edge), load the residual: strobes on positions 0..cnt-1, out_last=1, cnt=0. Return to ACCUM on the same edge.
- Output data bytes with strobe 0 are driven 0.
- Latency: one edge from the accepting input beat to out_valid. Back-to-back full beats sustain one word per cycle.
- Illegal inputs: in_bytes>NB is clamped to NB.

Test Plan:
- Aligned stream: in_first, offset 0; three beats of 16 bytes, values 0x00..0x2F; last on beat 3, out_ready=1 -> three words, strb=0xFFFF, data equal to input, out_last only on word 3, each word one cycle after its input.
- Leading offset: in_first, offset 5, 16 bytes 0xA0..0xAF, in_last -> word1: bytes 5..15 = 0xA0..0xAA, strb=0xFFE0, last=0. FLUSH word: bytes 0..4 = 0xAB..0xAF, strb=0x001F, last=1. in_ready=0 during FLUSH.
- Small chunks: offset 0; chunks of 3, 7 and 6 bytes (last) -> single word, strb=0xFFFF, bytes in arrival order, out_last=1, emitted one cycle after the third beat.
- Backpressure: out_ready=0 for 4 cycles with a word pending -> outputs stable, in_ready=0; the next input is accepted on the cycle out_ready rises. No loss or duplication.
- Zero-length last: after a 4-byte beat, send in_bytes=0 with in_last -> word with strb=0x000F, last=1. With cnt=0 instead -> strb=0x0000, last=1.
- Reset mid-packet: hold 9 residual bytes, pulse rst_n=0 for one edge -> out_valid=0. Next packet (offset 0, 16 bytes, last) yields exactly one word with strb=0xFFFF and no stale bytes.
